// File: rtl/mon_dispatch_pkg.sv
// rtl/mon_dispatch_pkg.sv - shared constants and elaboration helpers for the monitor dispatcher
package mon_dispatch_pkg;

   // Tag width covers the largest legal lane count, so tags are the same width for 2 or 4 lanes.
   localparam int LANE_IDX_W = 2;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

   function automatic bit lanes_legal(input int lanes);
      return (lanes == 2) || (lanes == 4);
   endfunction

endpackage

// File: rtl/mon_tag_fifo.sv
// rtl/mon_tag_fifo.sv - in-order lane tag FIFO; pointers carry an extra MSB for full/empty
module mon_tag_fifo
   import mon_dispatch_pkg::*;
#(
   parameter int WIDTH = 2,
   parameter int DEPTH = 4
)
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       push_data,
   output logic [WIDTH-1:0]       pop_data,
   output logic                   full,
   output logic                   empty,
   output logic [clog2(DEPTH):0]  count
);

   localparam int AW = clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   // A pop in the same cycle frees the slot, so a push at full is still accepted.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

   assign pop_data = mem[rd_ptr[AW-1:0]];
   assign count    = wr_ptr - rd_ptr;
   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/mon_dispatch.sv
// rtl/mon_dispatch.sv - round-robin dispatch of DUT transactions to checker lanes, in-order event collection
module mon_dispatch
   import mon_dispatch_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int LANES    = 2,
   parameter int TAGDEPTH = 4
)
(
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       i_valid,
   output logic                       o_ready,
   input  logic [WIDTH-1:0]           i_dut_ia,
   input  logic [WIDTH-1:0]           i_dut_ib,
   input  logic [WIDTH-1:0]           i_dut_os,
   output logic [LANES-1:0]           o_lane_valid,
   output logic [WIDTH-1:0]           o_lane_a,
   output logic [WIDTH-1:0]           o_lane_b,
   output logic [WIDTH-1:0]           o_lane_o,
   input  logic [LANES-1:0]           i_lane_ready,
   input  logic [LANES-1:0]           i_lane_done,
   input  logic [LANES*WIDTH-1:0]     i_lane_event,
   output logic [LANES-1:0]           o_lane_ack,
   output logic                       o_event_valid,
   output logic [WIDTH-1:0]           o_event,
   input  logic                       i_event_ready,
   output logic [clog2(TAGDEPTH):0]   o_outstanding
);

   if (!lanes_legal(LANES)) begin : g_bad_lanes
      $error("mon_dispatch: LANES must be 2 or 4");
   end

   logic                  cap_valid;
   logic [WIDTH-1:0]      cap_a;
   logic [WIDTH-1:0]      cap_b;
   logic [WIDTH-1:0]      cap_o;
   logic [LANE_IDX_W-1:0] rr_ptr;
   logic [LANE_IDX_W-1:0] grant_idx;
   logic [LANE_IDX_W-1:0] head_idx;
   logic [LANE_IDX_W-1:0] hi_idx;
   logic [LANE_IDX_W-1:0] lo_idx;
   logic                  hi_found;
   logic                  lo_found;
   logic                  grant_found;
   logic                  head_done;
   logic [WIDTH-1:0]      head_event;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  dispatch;
   logic                  collect;

   // Round-robin: lowest ready lane at or above rr_ptr, else wrap to the lowest ready lane.
   always_comb begin
      hi_idx   = '0;
      lo_idx   = '0;
      hi_found = 1'b0;
      lo_found = 1'b0;
      for (int k = LANES-1; k >= 0; k--) begin
         if (i_lane_ready[k]) begin
            lo_idx   = LANE_IDX_W'(k);
            lo_found = 1'b1;
            if (k >= int'(rr_ptr)) begin
               hi_idx   = LANE_IDX_W'(k);
               hi_found = 1'b1;
            end
         end
      end
      grant_found = lo_found;
      grant_idx   = hi_found ? hi_idx : lo_idx;
   end

   // Only the lane at the FIFO head may be collected; other done flags wait their turn.
   always_comb begin
      head_done  = 1'b0;
      head_event = '0;
      for (int k = 0; k < LANES; k++) begin
         if (head_idx == LANE_IDX_W'(k)) begin
            head_done  = i_lane_done[k];
            head_event = i_lane_event[k*WIDTH +: WIDTH];
         end
      end
   end

   assign collect  = !fifo_empty && head_done && (!o_event_valid || i_event_ready);
   assign dispatch = cap_valid && grant_found && (!fifo_full || collect);
   assign o_ready  = !cap_valid || dispatch;

   always_comb begin
      o_lane_valid = '0;
      o_lane_ack   = '0;
      for (int k = 0; k < LANES; k++) begin
         if (dispatch && grant_idx == LANE_IDX_W'(k)) o_lane_valid[k] = 1'b1;
         if (collect  && head_idx  == LANE_IDX_W'(k)) o_lane_ack[k]   = 1'b1;
      end
   end

   assign o_lane_a = cap_a;
   assign o_lane_b = cap_b;
   assign o_lane_o = cap_o;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cap_valid <= 1'b0;
         cap_a     <= '0;
         cap_b     <= '0;
         cap_o     <= '0;
      end else if (i_valid && o_ready) begin
         cap_valid <= 1'b1;
         cap_a     <= i_dut_ia;
         cap_b     <= i_dut_ib;
         cap_o     <= i_dut_os;
      end else if (dispatch) begin
         cap_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         rr_ptr <= '0;
      else if (dispatch)
         rr_ptr <= (grant_idx == LANE_IDX_W'(LANES-1)) ? '0 : grant_idx + LANE_IDX_W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         o_event_valid <= 1'b0;
         o_event       <= '0;
      end else if (collect) begin
         o_event_valid <= 1'b1;
         o_event       <= head_event;
      end else if (i_event_ready) begin
         o_event_valid <= 1'b0;
      end
   end

   mon_tag_fifo #(
      .WIDTH (LANE_IDX_W),
      .DEPTH (TAGDEPTH)
   ) u_tag_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (dispatch),
      .pop       (collect),
      .push_data (grant_idx),
      .pop_data  (head_idx),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (o_outstanding)
   );

endmodule

// File: tb/tb_mon_dispatch.sv
// tb/tb_mon_dispatch.sv - self-checking bench for mon_dispatch with a transaction-level reference model
module tb_mon_dispatch;

   localparam int W = 32;
   localparam int L = 2;
   localparam int D = 4;

   logic           clk = 1'b0;
   logic           reset;
   logic           i_valid;
   logic           o_ready;
   logic [W-1:0]   i_dut_ia, i_dut_ib, i_dut_os;
   logic [L-1:0]   o_lane_valid;
   logic [W-1:0]   o_lane_a, o_lane_b, o_lane_o;
   logic [L-1:0]   i_lane_ready;
   logic [L-1:0]   i_lane_done;
   logic [L*W-1:0] i_lane_event;
   logic [L-1:0]   o_lane_ack;
   logic           o_event_valid;
   logic [W-1:0]   o_event;
   logic           i_event_ready;
   logic [2:0]     o_outstanding;
   logic [W-1:0]   lane_ev [L];

   int errors = 0;
   int checks = 0;

   logic [W-1:0] lane_q [L][$];
   int           tagq [$];
   logic [W-1:0] exp_out [$];

   assign i_lane_event = {lane_ev[1], lane_ev[0]};

   mon_dispatch #(.WIDTH(W), .LANES(L), .TAGDEPTH(D)) dut (
      .clk(clk), .reset(reset), .i_valid(i_valid), .o_ready(o_ready),
      .i_dut_ia(i_dut_ia), .i_dut_ib(i_dut_ib), .i_dut_os(i_dut_os),
      .o_lane_valid(o_lane_valid), .o_lane_a(o_lane_a), .o_lane_b(o_lane_b), .o_lane_o(o_lane_o),
      .i_lane_ready(i_lane_ready), .i_lane_done(i_lane_done), .i_lane_event(i_lane_event),
      .o_lane_ack(o_lane_ack), .o_event_valid(o_event_valid), .o_event(o_event),
      .i_event_ready(i_event_ready), .o_outstanding(o_outstanding)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] ev_fn(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] o);
      return a + (b ^ o);
   endfunction

   task automatic set_txn(input logic [W-1:0] v);
      i_dut_ia = v;
      i_dut_ib = ~v;
      i_dut_os = v ^ 32'h5a5a_5a5a;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      i_valid = 1'b0;
      set_txn('0);
      i_lane_ready = '0;
      i_lane_done = '0;
      lane_ev[0] = '0;
      lane_ev[1] = '0;
      i_event_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", o_ready); end
      checks++; if (o_outstanding !== 3'd0) begin errors++; $display("FAIL reset_outstanding: got %0d expected 0", o_outstanding); end
      checks++; if (o_event_valid !== 1'b0) begin errors++; $display("FAIL reset_event_valid: got %b expected 0", o_event_valid); end
      checks++; if (o_event !== '0) begin errors++; $display("FAIL reset_event: got %h expected 0", o_event); end
      checks++; if (o_lane_valid !== 2'b00) begin errors++; $display("FAIL reset_lane_valid: got %b expected 00", o_lane_valid); end
      checks++; if (o_lane_ack !== 2'b00) begin errors++; $display("FAIL reset_lane_ack: got %b expected 00", o_lane_ack); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      do_reset();
      i_lane_ready = 2'b11;
      for (int i = 0; i < 5; i++) begin
         if (i < 4) begin i_valid = 1'b1; set_txn(W'(32'h100 + i)); end
         else i_valid = 1'b0;
         #1;
         if (i > 0) begin
            checks++; if (o_lane_valid !== 2'(1 << ((i-1) % 2))) begin errors++; $display("FAIL b2b_grant%0d: got %b expected %b", i-1, o_lane_valid, 2'(1 << ((i-1) % 2))); end
            checks++; if (o_lane_a !== W'(32'h100 + i - 1)) begin errors++; $display("FAIL b2b_data%0d: got %h expected %h", i-1, o_lane_a, W'(32'h100 + i - 1)); end
            checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d: got %b expected 1", i-1, o_ready); end
         end
         @(negedge clk);
      end
      #1;
      checks++; if (o_lane_valid !== 2'b00) begin errors++; $display("FAIL b2b_idle: got %b expected 00", o_lane_valid); end
      checks++; if (o_outstanding !== 3'd4) begin errors++; $display("FAIL b2b_outstanding: got %0d expected 4", o_outstanding); end
      @(negedge clk);
   endtask

   task automatic test_not_ready();
      do_reset();
      i_lane_ready = 2'b10;
      i_valid = 1'b1; set_txn(32'hA0);
      @(negedge clk);
      i_valid = 1'b0; #1;
      checks++; if (o_lane_valid !== 2'b10) begin errors++; $display("FAIL skip_grant: got %b expected 10", o_lane_valid); end
      checks++; if (o_lane_a !== 32'hA0) begin errors++; $display("FAIL skip_data: got %h expected a0", o_lane_a); end
      @(negedge clk);
      i_lane_ready = 2'b11; i_valid = 1'b1; set_txn(32'hA1);
      @(negedge clk);
      i_valid = 1'b0; #1;
      checks++; if (o_lane_valid !== 2'b01) begin errors++; $display("FAIL rr_return: got %b expected 01", o_lane_valid); end
      checks++; if (o_lane_a !== 32'hA1) begin errors++; $display("FAIL rr_return_data: got %h expected a1", o_lane_a); end
      @(negedge clk);
   endtask

   task automatic test_order();
      do_reset();
      i_lane_ready = 2'b11;
      i_valid = 1'b1; set_txn(32'h1);
      @(negedge clk);
      set_txn(32'h2);
      @(negedge clk);
      i_valid = 1'b0;
      @(negedge clk);
      lane_ev[0] = 32'hA; lane_ev[1] = 32'hB; i_lane_done = 2'b10;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (o_lane_ack !== 2'b00) begin errors++; $display("FAIL order_early_ack: got %b expected 00", o_lane_ack); end
         checks++; if (o_event_valid !== 1'b0) begin errors++; $display("FAIL order_early_event: got %b expected 0", o_event_valid); end
         @(negedge clk);
      end
      i_lane_done = 2'b11; #1;
      checks++; if (o_lane_ack !== 2'b01) begin errors++; $display("FAIL order_ack0: got %b expected 01", o_lane_ack); end
      @(negedge clk);
      i_lane_done = 2'b10; #1;
      checks++; if (o_lane_ack !== 2'b10) begin errors++; $display("FAIL order_ack1: got %b expected 10", o_lane_ack); end
      checks++; if ({o_event_valid, o_event} !== {1'b1, 32'hA}) begin errors++; $display("FAIL order_first: got %b/%h expected 1/a", o_event_valid, o_event); end
      @(negedge clk);
      i_lane_done = 2'b00; #1;
      checks++; if ({o_event_valid, o_event} !== {1'b1, 32'hB}) begin errors++; $display("FAIL order_second: got %b/%h expected 1/b", o_event_valid, o_event); end
      checks++; if (o_lane_ack !== 2'b00) begin errors++; $display("FAIL order_no_ack: got %b expected 00", o_lane_ack); end
      @(negedge clk); #1;
      checks++; if (o_event_valid !== 1'b0) begin errors++; $display("FAIL order_drain: got %b expected 0", o_event_valid); end
      checks++; if (o_outstanding !== 3'd0) begin errors++; $display("FAIL order_outstanding: got %0d expected 0", o_outstanding); end
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      do_reset();
      i_lane_ready = 2'b11; i_event_ready = 1'b0;
      i_valid = 1'b1; set_txn(32'h11);
      @(negedge clk);
      set_txn(32'h12);
      @(negedge clk);
      i_valid = 1'b0;
      @(negedge clk);
      lane_ev[0] = 32'h1234; lane_ev[1] = 32'h5678; i_lane_done = 2'b11; #1;
      checks++; if (o_lane_ack !== 2'b01) begin errors++; $display("FAIL bp_first_ack: got %b expected 01", o_lane_ack); end
      @(negedge clk);
      i_lane_done = 2'b10;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++; if ({o_event_valid, o_event} !== {1'b1, 32'h1234}) begin errors++; $display("FAIL bp_hold%0d: got %b/%h expected 1/1234", i, o_event_valid, o_event); end
         checks++; if (o_lane_ack !== 2'b00) begin errors++; $display("FAIL bp_no_ack%0d: got %b expected 00", i, o_lane_ack); end
         checks++; if (o_outstanding !== 3'd1) begin errors++; $display("FAIL bp_no_pop%0d: got %0d expected 1", i, o_outstanding); end
         @(negedge clk);
      end
      i_event_ready = 1'b1; #1;
      checks++; if (o_lane_ack !== 2'b10) begin errors++; $display("FAIL bp_release_ack: got %b expected 10", o_lane_ack); end
      @(negedge clk);
      i_lane_done = 2'b00; #1;
      checks++; if ({o_event_valid, o_event} !== {1'b1, 32'h5678}) begin errors++; $display("FAIL bp_next: got %b/%h expected 1/5678", o_event_valid, o_event); end
      checks++; if (o_outstanding !== 3'd0) begin errors++; $display("FAIL bp_outstanding: got %0d expected 0", o_outstanding); end
      @(negedge clk);
   endtask

   task automatic test_full();
      do_reset();
      i_lane_ready = 2'b11;
      for (int i = 0; i < 5; i++) begin
         i_valid = 1'b1; set_txn(W'(32'h200 + i));
         @(negedge clk);
      end
      set_txn(32'h205);
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL full_ready%0d: got %b expected 0", i, o_ready); end
         checks++; if (o_lane_valid !== 2'b00) begin errors++; $display("FAIL full_no_dispatch%0d: got %b expected 00", i, o_lane_valid); end
         checks++; if (o_outstanding !== 3'd4) begin errors++; $display("FAIL full_count%0d: got %0d expected 4", i, o_outstanding); end
         @(negedge clk);
      end
      lane_ev[0] = 32'hE0; lane_ev[1] = 32'hE1; i_lane_done = 2'b01; #1;
      checks++; if (o_lane_ack !== 2'b01) begin errors++; $display("FAIL full_pop_ack: got %b expected 01", o_lane_ack); end
      checks++; if ({o_lane_valid, o_lane_a} !== {2'b01, 32'h204}) begin errors++; $display("FAIL full_push: got %b/%h expected 01/204", o_lane_valid, o_lane_a); end
      checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL full_ready_swap: got %b expected 1", o_ready); end
      @(negedge clk);
      i_valid = 1'b0; i_lane_done = 2'b11; #1;
      checks++; if (o_outstanding !== 3'd4) begin errors++; $display("FAIL full_swap_count: got %0d expected 4", o_outstanding); end
      checks++; if ({o_event_valid, o_event} !== {1'b1, 32'hE0}) begin errors++; $display("FAIL full_event: got %b/%h expected 1/e0", o_event_valid, o_event); end
      checks++; if ({o_lane_valid, o_lane_a} !== {2'b10, 32'h205}) begin errors++; $display("FAIL full_push2: got %b/%h expected 10/205", o_lane_valid, o_lane_a); end
      for (int i = 0; i < 5; i++) begin
         checks++; if (o_lane_ack !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL full_drain%0d: got %b expected %b", i, o_lane_ack, (i % 2 == 0) ? 2'b10 : 2'b01); end
         @(negedge clk); #1;
      end
      checks++; if ({o_outstanding, o_lane_ack} !== {3'd0, 2'b00}) begin errors++; $display("FAIL full_empty: got %0d/%b expected 0/00", o_outstanding, o_lane_ack); end
      i_lane_done = 2'b00;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      do_reset();
      i_lane_ready = 2'b11;
      for (int i = 0; i < 3; i++) begin
         i_valid = 1'b1; set_txn(W'(32'h300 + i));
         @(negedge clk);
      end
      i_valid = 1'b0;
      @(negedge clk); #1;
      checks++; if (o_outstanding !== 3'd3) begin errors++; $display("FAIL mid_pre: got %0d expected 3", o_outstanding); end
      reset = 1'b1; i_lane_done = 2'b11; #1;
      checks++; if ({o_outstanding, o_event_valid, o_lane_ack} !== {3'd0, 1'b0, 2'b00}) begin errors++; $display("FAIL mid_reset: got %0d/%b/%b expected 0/0/00", o_outstanding, o_event_valid, o_lane_ack); end
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (o_lane_ack !== 2'b00) begin errors++; $display("FAIL mid_stale_ack%0d: got %b expected 00", i, o_lane_ack); end
         checks++; if ({o_outstanding, o_event_valid} !== {3'd0, 1'b0}) begin errors++; $display("FAIL mid_state%0d: got %0d/%b expected 0/0", i, o_outstanding, o_event_valid); end
         @(negedge clk);
      end
      i_lane_done = 2'b00;
   endtask

   task automatic test_random();
      bit           m_cap_valid, m_ev_valid, exp_collect, exp_disp, exp_rdy;
      bit           done_flag [L];
      logic [W-1:0] m_a, m_b, m_o, m_ev;
      logic [L-1:0] exp_lv, exp_ack;
      int           m_rr, g, k;
      do_reset();
      m_cap_valid = 0; m_ev_valid = 0; m_rr = 0;
      m_a = '0; m_b = '0; m_o = '0; m_ev = '0;
      tagq.delete(); exp_out.delete();
      for (int j = 0; j < L; j++) begin lane_q[j].delete(); done_flag[j] = 0; end
      for (int cyc = 0; cyc < 3000; cyc++) begin
         i_valid = ($urandom_range(0, 3) != 0);
         i_dut_ia = $urandom; i_dut_ib = $urandom; i_dut_os = $urandom;
         for (int j = 0; j < L; j++) begin
            i_lane_ready[j] = ($urandom_range(0, 3) != 0);
            if (lane_q[j].size() > 0 && !done_flag[j] && $urandom_range(0, 2) == 0) done_flag[j] = 1;
            i_lane_done[j] = done_flag[j];
            lane_ev[j] = (lane_q[j].size() > 0) ? lane_q[j][0] : W'($urandom);
         end
         i_event_ready = ($urandom_range(0, 9) < 7);
         #1;
         exp_collect = (tagq.size() > 0) && done_flag[tagq[0]] && (!m_ev_valid || i_event_ready);
         g = -1;
         for (int i = 0; i < L; i++) begin
            k = (m_rr + i) % L;
            if (g < 0 && i_lane_ready[k]) g = k;
         end
         exp_disp = m_cap_valid && (g >= 0) && ((tagq.size() < D) || exp_collect);
         exp_rdy  = !m_cap_valid || exp_disp;
         exp_lv   = exp_disp ? L'(1 << g) : '0;
         exp_ack  = exp_collect ? L'(1 << tagq[0]) : '0;
         checks++;
         if ({o_ready, o_lane_valid, o_lane_ack, o_event_valid} !== {exp_rdy, exp_lv, exp_ack, m_ev_valid}) begin
            errors++;
            $display("FAIL rand_ctrl cyc%0d: got rdy=%b lv=%b ack=%b ev=%b expected rdy=%b lv=%b ack=%b ev=%b",
                     cyc, o_ready, o_lane_valid, o_lane_ack, o_event_valid, exp_rdy, exp_lv, exp_ack, m_ev_valid);
         end
         checks++; if (o_outstanding !== 3'(tagq.size())) begin errors++; $display("FAIL rand_outstanding cyc%0d: got %0d expected %0d", cyc, o_outstanding, tagq.size()); end
         if (m_ev_valid) begin
            checks++; if (o_event !== m_ev) begin errors++; $display("FAIL rand_event cyc%0d: got %h expected %h", cyc, o_event, m_ev); end
         end
         if (exp_disp) begin
            checks++; if ({o_lane_a, o_lane_b, o_lane_o} !== {m_a, m_b, m_o}) begin errors++; $display("FAIL rand_lane_data cyc%0d: got %h/%h/%h expected %h/%h/%h", cyc, o_lane_a, o_lane_b, o_lane_o, m_a, m_b, m_o); end
         end
         if (m_ev_valid && i_event_ready) begin
            checks++;
            if (exp_out.size() == 0 || o_event !== exp_out[0]) begin errors++; $display("FAIL rand_stream_order cyc%0d: got %h expected %h", cyc, o_event, (exp_out.size() > 0) ? exp_out[0] : '0); end
            if (exp_out.size() > 0) void'(exp_out.pop_front());
         end
         if (exp_collect) begin
            k = tagq.pop_front();
            m_ev = lane_q[k].pop_front();
            done_flag[k] = 0;
            m_ev_valid = 1;
         end else if (i_event_ready) begin
            m_ev_valid = 0;
         end
         if (exp_disp) begin
            lane_q[g].push_back(ev_fn(m_a, m_b, m_o));
            tagq.push_back(g);
            m_rr = (g + 1) % L;
            m_cap_valid = 0;
         end
         if (i_valid && exp_rdy) begin
            m_a = i_dut_ia; m_b = i_dut_ib; m_o = i_dut_os;
            m_cap_valid = 1;
            exp_out.push_back(ev_fn(i_dut_ia, i_dut_ib, i_dut_os));
         end
         @(negedge clk);
      end
      i_valid = 1'b0;
      i_lane_done = '0;
   endtask

   initial begin
      reset = 1'b1;
      i_valid = 1'b0;
      set_txn('0);
      i_lane_ready = '0;
      i_lane_done = '0;
      lane_ev[0] = '0;
      lane_ev[1] = '0;
      i_event_ready = 1'b1;
      test_reset();
      test_back_to_back();
      test_not_ready();
      test_order();
      test_backpressure();
      test_full();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
